// File: rtl/window_generator.sv
// -----------------------------------------------------------------------------
// window_generator
//
// Turns a raster-order pixel stream into 3x3 windows for the kernel stage.
// Two line buffers hold the previous two rows; a small history array keeps the
// last two columns of each of the three window rows. A window is emitted for
// every accepted pixel at col >= 2 && row >= 2, one clock after the accept,
// through a single output register (no skid buffer).
//
// Window layout: out_data[DATA_WIDTH*i +: DATA_WIDTH] = w[i], i = 3*r + c,
// w[0] = (row-2, col-2) top-left, w[8] = (row, col) = the accepted pixel.
//
// Ports
//   clk        clock, single domain
//   rst        asynchronous, active-high reset
//   in_pixel   input pixel, raster order
//   in_valid   in_pixel valid
//   in_ready   block can accept in_pixel (combinational from out_ready)
//   in_sof     start of frame (only with SOF_RESYNC_EN)
//   out_data   3x3 window, DATA_WIDTH*9 bits
//   out_valid  out_data valid
//   out_ready  downstream accepts out_data
//   out_last   out_data is the last window of the frame
//
// Configuration macro
//   SOF_RESYNC_EN  adds in_sof; an accepted pixel with in_sof=1 is taken as
//                  (0,0), aborting any partial frame. Without it the counters
//                  free-run and framing is purely IMG_WIDTH*IMG_HEIGHT pixels
//                  since reset.
// -----------------------------------------------------------------------------
module window_generator #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 16,
    parameter int IMG_HEIGHT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   in_pixel,
    input  logic                    in_valid,
    output logic                    in_ready,
`ifdef SOF_RESYNC_EN
    input  logic                    in_sof,
`endif
    output logic [DATA_WIDTH*9-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0]          col_q, col_d, cur_col;
    logic [RW-1:0]          row_q, row_d, cur_row;
    logic                   accept;
    logic                   emit;

    logic [DATA_WIDTH-1:0]  lb0 [IMG_WIDTH];   // row-1
    logic [DATA_WIDTH-1:0]  lb1 [IMG_WIDTH];   // row-2
    logic [DATA_WIDTH-1:0]  hist_q [3][2];     // per window row: [0]=col-2, [1]=col-1
    logic [DATA_WIDTH-1:0]  win_d [9];

    logic                   out_valid_q, out_valid_d;
    logic                   out_last_q, out_last_d;
    logic [DATA_WIDTH*9-1:0] out_data_q, out_data_d;

    // A pixel can be taken whenever the output register is empty or being
    // drained this cycle; reset forces it low.
    assign in_ready = !rst && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        cur_col     = col_q;
        cur_row     = row_q;
`ifdef SOF_RESYNC_EN
        if (in_sof) begin
            cur_col = '0;
            cur_row = '0;
        end
`endif
        // Columns 0-1 of each row still carry stale history from the previous
        // row; the col >= 2 gate discards those windows.
        emit = accept && (cur_col >= CW'(2)) && (cur_row >= RW'(2));

        for (int r = 0; r < 3; r++) begin
            win_d[3*r]     = hist_q[r][0];
            win_d[3*r + 1] = hist_q[r][1];
        end
        win_d[2] = lb1[cur_col];
        win_d[5] = lb0[cur_col];
        win_d[8] = in_pixel;

        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
                row_d = cur_row;
            end
        end

        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (emit) begin
            out_valid_d = 1'b1;
            for (int i = 0; i < 9; i++) begin
                out_data_d[i*DATA_WIDTH +: DATA_WIDTH] = win_d[i];
            end
            out_last_d = (cur_col == COL_LAST) && (cur_row == ROW_LAST);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    // NOTE: line buffers and window history are storage, not control state,
    // so they carry no reset; the col/row emit gate guarantees no window is
    // built from anything written before the last reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[cur_col] <= lb0[cur_col];
            lb0[cur_col] <= in_pixel;
            for (int r = 0; r < 3; r++) begin
                hist_q[r][0] <= win_d[3*r + 1];
                hist_q[r][1] <= win_d[3*r + 2];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_window_generator.sv
// -----------------------------------------------------------------------------
// tb_window_generator
//
// Bench for window_generator at IMG_WIDTH=5, IMG_HEIGHT=4. A negedge monitor
// keeps its own copy of the accepted image, pushes the expected window for
// every emitting pixel and pops/compares it when the DUT hands a window over.
// A vector table covers the full-rate first frame cycle by cycle; hand-written
// sequences cover backpressure, random throttling, mid-frame reset and (with
// SOF_RESYNC_EN) start-of-frame resync.
// -----------------------------------------------------------------------------
module tb_window_generator;

    localparam int DW = 8;
    localparam int W  = 5;
    localparam int H  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [DW-1:0]   in_pixel = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            in_sof = 1'b0;
    logic [DW*9-1:0] out_data;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            out_last;

    always #5 clk = ~clk;

    window_generator #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_pixel  (in_pixel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef SOF_RESYNC_EN
        .in_sof    (in_sof),
`endif
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    typedef struct {
        logic [DW*9-1:0] data;
        logic            last;
    } win_t;

    typedef struct {
        logic [DW-1:0] pixel;
        logic          exp_valid;
        logic [DW-1:0] w0;
        logic [DW-1:0] w4;
        logic [DW-1:0] w8;
        logic          last;
    } vec_t;

    win_t          exp_q [$];
    logic [DW-1:0] got_w8 [$];
    int            tests  = 0;
    int            failed = 0;

    // Monitor's model of the frame, independent of the DUT's buffers.
    logic [DW-1:0] img [H][W];
    int            m_col = 0;
    int            m_row = 0;

    // Stimulus position, used to form pixel values.
    int            s_col = 0;
    int            s_row = 0;

    vec_t          tbl [20];

    task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] w8_at(input int i);
        if (i < got_w8.size()) return got_w8[i];
        return 'x;
    endfunction

    // Scoreboard monitor, sampling half a cycle away from the active edge.
    always @(negedge clk) begin
        win_t e;
        if (rst) begin
            exp_q.delete();
            m_col = 0;
            m_row = 0;
        end else begin
            if (out_valid && out_ready) begin
                got_w8.push_back(out_data[DW*8 +: DW]);
                if (exp_q.size() == 0) begin
                    check("unexpected_window", {7'd0, out_last, out_data}, 80'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("window", {7'd0, out_last, out_data}, {7'd0, e.last, e.data});
                end
            end
            if (in_valid && in_ready) begin
`ifdef SOF_RESYNC_EN
                if (in_sof) begin
                    m_col = 0;
                    m_row = 0;
                end
`endif
                img[m_row][m_col] = in_pixel;
                if (m_row >= 2 && m_col >= 2) begin
                    for (int r = 0; r < 3; r++)
                        for (int c = 0; c < 3; c++)
                            e.data[DW*(3*r+c) +: DW] = img[m_row-2+r][m_col-2+c];
                    e.last = (m_col == W-1) && (m_row == H-1);
                    exp_q.push_back(e);
                end
                if (m_col == W-1) begin
                    m_col = 0;
                    m_row = (m_row == H-1) ? 0 : m_row + 1;
                end else begin
                    m_col++;
                end
            end
        end
    end

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 80'(out_valid), 80'(0));
        check("reset_out_last",  80'(out_last),  80'(0));
        check("reset_out_data",  80'(out_data),  80'(0));
        check("reset_in_ready",  80'(in_ready),  80'(0));
        s_col = 0;
        s_row = 0;
        rst   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Sends n pixels valued ofs + 16*row + col with random valid/ready rates.
    task automatic run_pixels(input int n, input int ofs, input int pv, input int pr);
        int sent = 0;
        int cyc  = 0;
        while (sent < n) begin
            if (cyc >= n*40 + 50) begin
                check("run_pixels_timeout", 80'(sent), 80'(n));
                break;
            end
            cyc++;
            in_valid  = (int'($urandom_range(99)) < pv);
            out_ready = (int'($urandom_range(99)) < pr);
            in_sof    = 1'b0;
            in_pixel  = in_valid ? DW'(ofs + 16*s_row + s_col) : DW'($urandom);
            @(negedge clk);
            if (in_valid && in_ready) begin
                sent++;
                if (s_col == W-1) begin
                    s_col = 0;
                    s_row = (s_row == H-1) ? 0 : s_row + 1;
                end else begin
                    s_col++;
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("drain_queue_empty", 80'(exp_q.size()), 80'(0));
    endtask

    task automatic check_vec(input int j);
        check($sformatf("vec%0d_out_valid", j), 80'(out_valid), 80'(tbl[j].exp_valid));
        if (tbl[j].exp_valid) begin
            check($sformatf("vec%0d_w0", j),   80'(out_data[0 +: DW]),    80'(tbl[j].w0));
            check($sformatf("vec%0d_w4", j),   80'(out_data[DW*4 +: DW]), 80'(tbl[j].w4));
            check($sformatf("vec%0d_w8", j),   80'(out_data[DW*8 +: DW]), 80'(tbl[j].w8));
            check($sformatf("vec%0d_last", j), 80'(out_last),             80'(tbl[j].last));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Expected windows for a plain frame, keyed by the pixel that emits.
        for (int i = 0; i < 20; i++)
            tbl[i] = '{pixel: DW'(16*(i/W) + i%W), exp_valid: 1'b0,
                       w0: '0, w4: '0, w8: '0, last: 1'b0};
        tbl[12] = '{8'h22, 1'b1, 8'h00, 8'h11, 8'h22, 1'b0};
        tbl[13] = '{8'h23, 1'b1, 8'h01, 8'h12, 8'h23, 1'b0};
        tbl[14] = '{8'h24, 1'b1, 8'h02, 8'h13, 8'h24, 1'b0};
        tbl[17] = '{8'h32, 1'b1, 8'h10, 8'h21, 8'h32, 1'b0};
        tbl[18] = '{8'h33, 1'b1, 8'h11, 8'h22, 8'h33, 1'b0};
        tbl[19] = '{8'h34, 1'b1, 8'h12, 8'h23, 8'h34, 1'b1};

        #1;
        do_reset();

        // Basic frame at full throughput, checked cycle by cycle.
        got_w8.delete();
        for (int i = 0; i < 20; i++) begin
            in_valid  = 1'b1;
            in_pixel  = tbl[i].pixel;
            out_ready = 1'b1;
            @(negedge clk);
            check("full_rate_in_ready", 80'(in_ready), 80'(1));
            if (i > 0) check_vec(i - 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check_vec(19);
        @(posedge clk);
        #1;
        drain();
        check("basic_window_count", 80'(got_w8.size()), 80'(6));

        // Backpressure while the (2,3) window is pending.
        got_w8.delete();
        run_pixels(14, 0, 100, 100);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pixel  = 8'h24;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_in_ready",  80'(in_ready),  80'(0));
            check("stall_out_valid", 80'(out_valid), 80'(1));
            check("stall_out_data",  80'(out_data),  80'(72'h232221131211030201));
            check("stall_out_last",  80'(out_last),  80'(0));
            @(posedge clk);
            #1;
        end
        run_pixels(6, 0, 100, 100);
        drain();
        check("bp_window_count", 80'(got_w8.size()), 80'(6));
        check("bp_second_w8",    80'(w8_at(1)),      80'(8'h23));
        check("bp_third_w8",     80'(w8_at(2)),      80'(8'h24));

        // Random throttle over three back-to-back frames; frames alternate an
        // offset so any cross-frame pixel leak changes the window.
        got_w8.delete();
        run_pixels(20, 8'h80, 60, 60);
        run_pixels(20, 8'h00, 60, 60);
        run_pixels(20, 8'h80, 60, 60);
        drain();
        check("rand_window_count",  80'(got_w8.size()), 80'(18));
        check("rand_frame2_first",  80'(w8_at(6)),      80'(8'h22));

        // Reset mid-frame with a window pending.
        do_reset();
        run_pixels(13, 0, 100, 100);
        check("rst_pre_out_valid", 80'(out_valid), 80'(1));
        #2 rst = 1'b1;
        #1;
        check("rst_async_out_valid", 80'(out_valid), 80'(0));
        check("rst_async_in_ready",  80'(in_ready),  80'(0));
        do_reset();
        got_w8.delete();
        run_pixels(20, 8'h40, 100, 100);
        drain();
        check("post_rst_window_count", 80'(got_w8.size()), 80'(6));
        check("post_rst_first_w8",     80'(w8_at(0)),      80'(8'h62));
        check("post_rst_last_w8",      80'(w8_at(5)),      80'(8'h74));

`ifdef SOF_RESYNC_EN
        // in_sof on the 8th pixel restarts the frame at (0,0).
        do_reset();
        run_pixels(7, 0, 100, 100);
        got_w8.delete();
        in_valid  = 1'b1;
        in_sof    = 1'b1;
        in_pixel  = 8'h40;
        out_ready = 1'b1;
        @(negedge clk);
        check("sof_accept", 80'(in_ready), 80'(1));
        @(posedge clk);
        #1;
        in_sof   = 1'b0;
        in_valid = 1'b0;
        s_col    = 1;
        s_row    = 0;
        run_pixels(19, 8'h40, 100, 100);
        drain();
        check("sof_window_count", 80'(got_w8.size()), 80'(6));
        check("sof_first_w8",     80'(w8_at(0)),      80'(8'h62));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
